// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, RV32I
// load/store funct3 codes, byte-enable, lane-replication and legality helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   byte_en = 4'b0001 << addr_lo;
            2'b01:   byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // The bus slave picks the lane it needs from a replicated store word.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   store_lanes = {4{wdata[7:0]}};
            2'b01:   store_lanes = {2{wdata[15:0]}};
            default: store_lanes = wdata;
        endcase
    endfunction

    function automatic logic is_legal(input logic write, input logic [2:0] funct3);
        if (write)
            is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        is_misaligned = ((size == 2'b01) && addr_lo[0]) || ((size == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Word-wide external data bus between the responder (master) and memory (slave).
interface dmem_responder_if #(
    parameter int ADDR_W = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dmem_load_ext.sv
// Load lane select plus sign/zero extension of a bus word into a 32-bit result.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_W:    result = word;
            F3_BU:   result = {24'd0, byte_sel};
            F3_HU:   result = {16'd0, half_sel};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: runs one req/ack bus cycle per core access and stalls
// the core until it completes. Optional macro DMEM_MISALIGN_CHECK_EN traps
// misaligned half/word accesses without touching the bus.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mreq,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              valid,
    output logic              bus_err,
    output logic              misalign,
    dmem_responder_if.master  bus
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_e            state_q, state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              misalign_q, misalign_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic              misalign_req;
    logic [31:0]       load_data;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign_req = is_misaligned(funct3[1:0], addr[1:0]);
`else
    assign misalign_req = 1'b0;
`endif

    dmem_load_ext u_load_ext (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .word    (bus.mem_rdata),
        .result  (load_data)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        bus_err_d   = bus_err_q;
        misalign_d  = misalign_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;

        case (state_q)
            IDLE: begin
                wait_cnt_d = 8'd0;
                bus_err_d  = 1'b0;
                misalign_d = 1'b0;
                if (mreq) begin
                    funct3_d  = funct3;
                    addr_lo_d = addr[1:0];
                    rdata_d   = 32'd0;
                    if (!is_legal(mem_write, funct3)) begin
                        bus_err_d = 1'b1;
                        state_d   = DONE;
                    end else if (misalign_req) begin
                        misalign_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = mem_write;
                        mem_be_d    = byte_en(funct3[1:0], addr[1:0]);
                        mem_addr_d  = addr[ADDR_W-1:2];
                        mem_wdata_d = mem_write ? store_lanes(funct3[1:0], wdata) : 32'd0;
                        state_d     = BUS;
                    end
                end
            end
            BUS: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                // An ack on the final allowed cycle still completes the access.
                if (bus.mem_ack) begin
                    rdata_d   = mem_we_q ? 32'd0 : load_data;
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    rdata_d   = 32'd0;
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d    = IDLE;
                wait_cnt_d = 8'd0;
                bus_err_d  = 1'b0;
                misalign_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge; every register, data included, is cleared.
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            bus_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
            misalign_q  <= misalign_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
        end
    end

    assign stall         = rst_n & mreq & (state_q != DONE);
    assign valid         = (state_q == DONE);
    assign rdata         = rdata_q;
    assign bus_err       = bus_err_q;
    assign misalign      = misalign_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_MAX=4) with a small
// bus responder that acks after a chosen number of wait states.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mreq = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall, valid, bus_err, misalign;
    logic [31:0] rdata;

    dmem_responder_if #(.ADDR_W(32)) bus_if ();

    dmem_responder #(.ADDR_W(32), .WAIT_MAX(WAIT_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mreq      (mreq),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .rdata     (rdata),
        .valid     (valid),
        .bus_err   (bus_err),
        .misalign  (misalign),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Observations from the most recent access
    int          o_stall, o_bus, o_done_cycle;
    logic        o_done, o_err, o_mis, o_req_done, o_saw_req, o_we, o_valid_after;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_be;

    // waits < 0 means the bus never acks
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int waits);
        mreq = 1'b1; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        bus_if.mem_rdata = rd; bus_if.mem_ack = 1'b0;
        o_stall = 0; o_bus = 0; o_done_cycle = -1; o_done = 1'b0; o_err = 1'b0; o_mis = 1'b0;
        o_req_done = 1'b0; o_saw_req = 1'b0; o_we = 1'b0; o_rdata = 32'hx;
        o_addr = 32'd0; o_wdata = 32'd0; o_be = 4'd0;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (valid) begin
                o_done = 1'b1; o_done_cycle = c; o_rdata = rdata; o_err = bus_err;
                o_mis = misalign; o_req_done = bus_if.mem_req;
                break;
            end
            if (stall) o_stall++;
            if (bus_if.mem_req) begin
                o_saw_req = 1'b1; o_be = bus_if.mem_be; o_we = bus_if.mem_we;
                o_addr = {2'b00, bus_if.mem_addr}; o_wdata = bus_if.mem_wdata;
                bus_if.mem_ack = (o_bus == waits);
                o_bus++;
            end else begin
                bus_if.mem_ack = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("valid_seen", {31'd0, o_done}, 32'd1);
        mreq = 1'b0; bus_if.mem_ack = 1'b0;
        @(posedge clk); #1;
        o_valid_after = valid;
    endtask

    initial begin
        bus_if.mem_rdata = 32'd0;
        bus_if.mem_ack   = 1'b0;

        // Reset: outputs low and stall forced low even with mreq high
        mreq = 1'b1; funct3 = F3_W;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_mem_req", {31'd0, bus_if.mem_req}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        mreq = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        // SW 0x100, ack in first BUS cycle
        access(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'hFFFFFFFF, 0);
        check("sw_addr", o_addr, 32'h40);
        check("sw_be", {28'd0, o_be}, 32'hF);
        check("sw_we", {31'd0, o_we}, 32'd1);
        check("sw_wdata", o_wdata, 32'hDEADBEEF);
        check("sw_stall", o_stall, 2);
        check("sw_done_cycle", o_done_cycle, 2);
        check("sw_rdata", o_rdata, 32'd0);
        check("sw_err", {31'd0, o_err}, 32'd0);
        check("sw_valid_1cyc", {31'd0, o_valid_after}, 32'd0);

        // SB / SH lane replication
        access(1'b1, F3_B, 32'h103, 32'h000000A5, 32'd0, 0);
        check("sb_be", {28'd0, o_be}, 32'h8);
        check("sb_wdata", o_wdata, 32'hA5A5A5A5);
        access(1'b1, F3_H, 32'h102, 32'h00001234, 32'd0, 0);
        check("sh_be", {28'd0, o_be}, 32'hC);
        check("sh_wdata", o_wdata, 32'h12341234);

        // LB / LBU byte 1 of 0x123480FF
        access(1'b0, F3_B, 32'h101, 32'd0, 32'h123480FF, 0);
        check("lb_rdata", o_rdata, 32'hFFFFFF80);
        check("lb_be", {28'd0, o_be}, 32'h2);
        check("lb_we", {31'd0, o_we}, 32'd0);
        access(1'b0, F3_BU, 32'h101, 32'd0, 32'h123480FF, 0);
        check("lbu_rdata", o_rdata, 32'h00000080);

        // LH with 3 wait states: ack on the last allowed BUS cycle
        access(1'b0, F3_H, 32'h102, 32'd0, 32'h8001ABCD, 3);
        check("lh_rdata", o_rdata, 32'hFFFF8001);
        check("lh_stall", o_stall, 5);
        check("lh_err", {31'd0, o_err}, 32'd0);
        access(1'b0, F3_HU, 32'h102, 32'd0, 32'h8001ABCD, 0);
        check("lhu_rdata", o_rdata, 32'h00008001);

        // Timeout: no ack
        access(1'b0, F3_W, 32'h300, 32'd0, 32'h5A5A5A5A, -1);
        check("to_bus_cycles", o_bus, 4);
        check("to_err", {31'd0, o_err}, 32'd1);
        check("to_rdata", o_rdata, 32'd0);
        check("to_mem_req", {31'd0, o_req_done}, 32'd0);
        check("to_stall", o_stall, 5);
        check("to_err_clear", {31'd0, bus_err}, 32'd0);

        // Illegal funct3: no bus cycle
        access(1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 0);
        check("ill_ld_err", {31'd0, o_err}, 32'd1);
        check("ill_ld_req", {31'd0, o_saw_req}, 32'd0);
        check("ill_ld_stall", o_stall, 1);
        access(1'b1, 3'b100, 32'h10, 32'h1, 32'd0, 0);
        check("ill_st_err", {31'd0, o_err}, 32'd1);
        check("ill_st_req", {31'd0, o_saw_req}, 32'd0);

        // LW to a non-word-aligned address
        access(1'b0, F3_W, 32'h102, 32'd0, 32'h11223344, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("mis_flag", {31'd0, o_mis}, 32'd1);
        check("mis_req", {31'd0, o_saw_req}, 32'd0);
        check("mis_rdata", o_rdata, 32'd0);
`else
        check("mis_flag", {31'd0, o_mis}, 32'd0);
        check("mis_rdata", o_rdata, 32'h11223344);
        check("mis_be", {28'd0, o_be}, 32'hF);
`endif

        // mem_ack while idle is ignored
        bus_if.mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ack_valid", {31'd0, valid}, 32'd0);
        check("idle_ack_req", {31'd0, bus_if.mem_req}, 32'd0);
        bus_if.mem_ack = 1'b0;

        // Reset during BUS abandons the access
        mreq = 1'b1; mem_write = 1'b0; funct3 = F3_W; addr = 32'h200;
        @(posedge clk); #1;
        check("mid_req_before", {31'd0, bus_if.mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_stall_rst", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        check("mid_req_after", {31'd0, bus_if.mem_req}, 32'd0);
        check("mid_valid_after", {31'd0, valid}, 32'd0);
        mreq = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b0, F3_W, 32'h10, 32'd0, 32'hCAFEF00D, 0);
        check("post_rst_stall", o_stall, 2);
        check("post_rst_rdata", o_rdata, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
